// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles with an error response.
module apb_master_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_strb,
   input  logic [5:0]  req_prot,
   output logic [1:0]  req_ready,
   output logic [1:0]  rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic [3:0]  pstrb,
   output logic [2:0]  pprot,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   logic [1:0]  state;
   logic        last_grant, owner, gnt, start, done, fail, sel_write;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  strb_q;
   logic [2:0]  prot_q;
   logic        write_q;
   always_comb begin
      gnt       = (&req_valid) ? ~last_grant : req_valid[1];
      start     = presetn && (state == IDLE) && (|req_valid);
      req_ready = start ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      sel_write = gnt ? req_write[1] : req_write[0];
      done      = (state == ACCESS) && pready;
   end
`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
   always_ff @(posedge pclk) begin
      if (!presetn || state == SETUP)
         wait_cnt <= '0;
      else if (state == ACCESS && !pready)
         wait_cnt <= wait_cnt + 1'b1;
   end
   assign fail = (state == ACCESS) && !pready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign fail = 1'b0;
`endif
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
         prot_q     <= '0;
         write_q    <= 1'b0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (start) begin
            state      <= SETUP;
            last_grant <= gnt;
            owner      <= gnt;
            write_q    <= sel_write;
            addr_q     <= gnt ? req_addr[63:32] : req_addr[31:0];
            wdata_q    <= !sel_write ? 32'h0 : gnt ? req_wdata[63:32] : req_wdata[31:0];
            strb_q     <= !sel_write ? 4'h0 : gnt ? req_strb[7:4] : req_strb[3:0];
            prot_q     <= gnt ? req_prot[5:3] : req_prot[2:0];
         end else if (state == SETUP) begin
            state <= ACCESS;
         end else if (done || fail) begin
            state     <= IDLE;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_err   <= pslverr || fail;
            rsp_rdata <= (write_q || fail) ? 32'h0 : prdata;
         end
      end
   end
   assign psel    = (state == SETUP) || (state == ACCESS);
   assign penable = (state == ACCESS);
   assign pwrite  = write_q;
   assign paddr   = addr_q;
   assign pwdata  = wdata_q;
   assign pstrb   = strb_q;
   assign pprot   = prot_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of arbitration, APB phasing, responses, reset abort and timeout.
module tb_apb_master_arbiter;
   logic        pclk, presetn;
   logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_strb;
   logic [5:0]  req_prot;
   logic [31:0] rsp_rdata, paddr, pwdata, prdata;
   logic        rsp_err, psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   int vec, errs;

   apb_master_arbiter dut (
      .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset;
      @(negedge pclk);
      #1;
      vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL rst_ready: got %b exp 00", req_ready); end
      vec++; if ({psel, penable, pwrite} !== 3'b000) begin errs++; $display("FAIL rst_ctrl: got %b exp 000", {psel, penable, pwrite}); end
      vec++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL rst_rsp: got %b %b %h exp 00 0 0", rsp_valid, rsp_err, rsp_rdata); end
      vec++; if ({paddr, pwdata, pstrb, pprot} !== 71'h0) begin errs++; $display("FAIL rst_fields: got %h %h %h %h exp 0", paddr, pwdata, pstrb, pprot); end
      req_valid = 2'b00;
      presetn = 1'b1;
   endtask

   task automatic test_single_write;
      @(negedge pclk);
      req_valid = 2'b01; req_write = 2'b01;
      req_addr = {32'h0, 32'h4000_0010}; req_wdata = {32'h0, 32'hA5A5_0001};
      req_strb = 8'h0F; req_prot = 6'b000_010;
      pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234_5678;
      #1;
      vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL wr_ready: got %b exp 01", req_ready); end
      @(negedge pclk);
      req_valid = 2'b00;
      vec++; if ({psel, penable} !== 2'b10) begin errs++; $display("FAIL wr_setup: got %b exp 10", {psel, penable}); end
      vec++; if (paddr !== 32'h4000_0010 || pwdata !== 32'hA5A5_0001) begin errs++; $display("FAIL wr_addr_data: got %h %h exp 40000010 a5a50001", paddr, pwdata); end
      vec++; if ({pwrite, pstrb, pprot} !== {1'b1, 4'hF, 3'b010}) begin errs++; $display("FAIL wr_attr: got %b %h %b exp 1 f 010", pwrite, pstrb, pprot); end
      @(negedge pclk);
      vec++; if ({psel, penable} !== 2'b11 || paddr !== 32'h4000_0010) begin errs++; $display("FAIL wr_access: got %b %h exp 11 40000010", {psel, penable}, paddr); end
      @(negedge pclk);
      vec++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL wr_rsp: got %b %b %h exp 01 0 0", rsp_valid, rsp_err, rsp_rdata); end
      vec++; if ({psel, penable} !== 2'b00) begin errs++; $display("FAIL wr_idle: got %b exp 00", {psel, penable}); end
      @(negedge pclk);
      vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL wr_rsp_pulse: got %b exp 00", rsp_valid); end
   endtask

   task automatic test_round_robin;
      logic       exp;
      logic [1:0] oh;
      @(negedge pclk);
      presetn = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      req_valid = 2'b11; req_write = 2'b11;
      req_addr = {32'h2000_0004, 32'h1000_0008}; req_wdata = {32'h2222_2222, 32'h1111_1111};
      req_strb = 8'hFF; req_prot = 6'b000_000; pready = 1'b1;
      #1;
      vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL rr_first: got %b exp 01", req_ready); end
      exp = 1'b0;
      for (int r = 0; r < 4; r++) begin
         @(negedge pclk);
         vec++; if (paddr !== (exp ? 32'h2000_0004 : 32'h1000_0008)) begin errs++; $display("FAIL rr_paddr%0d: got %h exp owner %0d", r, paddr, exp); end
         @(negedge pclk);
         @(negedge pclk);
         oh = exp ? 2'b10 : 2'b01;
         vec++; if (rsp_valid !== oh) begin errs++; $display("FAIL rr_rsp%0d: got %b exp %b", r, rsp_valid, oh); end
         exp = ~exp;
         if (r == 3) req_valid = 2'b00;
         #1;
         oh = exp ? 2'b10 : 2'b01;
         if (r < 3) begin
            vec++; if (req_ready !== oh) begin errs++; $display("FAIL rr_grant%0d: got %b exp %b", r + 1, req_ready, oh); end
         end
      end
      @(negedge pclk);
      vec++; if (psel !== 1'b0) begin errs++; $display("FAIL rr_quiet: got %b exp 0", psel); end
   endtask

   task automatic test_read_wait;
      @(negedge pclk);
      req_valid = 2'b10; req_write = 2'b00;
      req_addr = {32'h3000_0040, 32'h0}; req_wdata = {32'hFFFF_FFFF, 32'h0};
      req_strb = 8'hF0; req_prot = 6'b101_000; pready = 1'b0; pslverr = 1'b0;
      #1;
      vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL rd_ready: got %b exp 10", req_ready); end
      for (int i = 1; i <= 5; i++) begin
         @(negedge pclk);
         if (i == 1) begin
            req_valid = 2'b00;
            vec++; if ({pwrite, pstrb, pwdata} !== 37'h0) begin errs++; $display("FAIL rd_attr: got %b %h %h exp 0 0 0", pwrite, pstrb, pwdata); end
            vec++; if (pprot !== 3'b101) begin errs++; $display("FAIL rd_prot: got %b exp 101", pprot); end
         end
         vec++; if (paddr !== 32'h3000_0040) begin errs++; $display("FAIL rd_paddr%0d: got %h exp 30000040", i, paddr); end
         vec++; if ({psel, penable} !== ((i == 1) ? 2'b10 : 2'b11)) begin errs++; $display("FAIL rd_phase%0d: got %b", i, {psel, penable}); end
         vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rd_early_rsp%0d: got %b exp 00", i, rsp_valid); end
         if (i == 5) begin
            pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
         end
      end
      @(negedge pclk);
      vec++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b1) begin errs++; $display("FAIL rd_rsp: got %b %h %b exp 10 deadbeef 1", rsp_valid, rsp_rdata, rsp_err); end
      pslverr = 1'b0; prdata = 32'h0;
   endtask

   task automatic test_reset_abort;
      @(negedge pclk);
      req_valid = 2'b01; req_write = 2'b01;
      req_addr = {32'h0, 32'h5000_0000}; pready = 1'b0;
      #1;
      vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL ab_ready: got %b exp 01", req_ready); end
      @(negedge pclk);
      req_valid = 2'b00;
      @(negedge pclk);
      vec++; if ({psel, penable} !== 2'b11) begin errs++; $display("FAIL ab_access: got %b exp 11", {psel, penable}); end
      presetn = 1'b0;
      @(negedge pclk);
      vec++; if ({psel, penable} !== 2'b00 || rsp_valid !== 2'b00) begin errs++; $display("FAIL ab_drop: got %b %b exp 00 00", {psel, penable}, rsp_valid); end
      presetn = 1'b1;
      req_valid = 2'b11; req_write = 2'b11; pready = 1'b1;
      #1;
      vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL ab_regrant: got %b exp 01", req_ready); end
      @(negedge pclk);
      req_valid = 2'b00;
      vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL ab_no_rsp: got %b exp 00", rsp_valid); end
      @(negedge pclk);
      @(negedge pclk);
      vec++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL ab_rsp: got %b exp 01", rsp_valid); end
   endtask

   task automatic test_timeout;
      int n;
      @(negedge pclk);
      req_valid = 2'b01; req_write = 2'b00;
      req_addr = {32'h0, 32'h6000_0000}; pready = 1'b0; prdata = 32'hCAFE_F00D; pslverr = 1'b0;
      #1;
      vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL to_ready: got %b exp 01", req_ready); end
      @(negedge pclk);
      req_valid = 2'b00;
      n = 0;
`ifdef APB_ARB_TIMEOUT_EN
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            if (psel && penable) n++;
            else begin
               hit = 1'b1;
               break;
            end
         end
         vec++; if (hit !== 1'b1) begin errs++; $display("FAIL to_bound: psel still high after 200 cycles"); end
         vec++; if (n !== 16) begin errs++; $display("FAIL to_cycles: got %0d exp 16", n); end
         vec++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL to_rsp: got %b %b %h exp 01 1 0", rsp_valid, rsp_err, rsp_rdata); end
      end
`else
      for (int i = 0; i < 100; i++) begin
         @(negedge pclk);
         if (psel && penable && rsp_valid == 2'b00) n++;
      end
      vec++; if (n !== 100) begin errs++; $display("FAIL to_wait: got %0d held cycles exp 100", n); end
      presetn = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      vec++; if (psel !== 1'b0) begin errs++; $display("FAIL to_release: got %b exp 0", psel); end
`endif
      pready = 1'b1;
   endtask

   initial begin
      vec = 0; errs = 0;
      presetn = 1'b0;
      req_valid = 2'b11; req_write = 2'b11;
      req_addr = {32'hFFFF_0000, 32'hEEEE_0000}; req_wdata = {32'h1, 32'h2};
      req_strb = 8'hFF; req_prot = 6'b111_111;
      prdata = 32'h0; pready = 1'b1; pslverr = 1'b0;
      test_reset();
      test_single_write();
      test_round_robin();
      test_read_wait();
      test_reset_abort();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the ACCESS-phase wait limit used only when APB_ARB_TIMEOUT_EN is defined.
REQ-002 pclk  input  1  single clock; all logic on rising edge.
REQ-003 presetn  input  1  synchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester transfer request, bit N = requester N.
REQ-005 req_write  input  2  per-requester direction, 1 = write.
REQ-006 req_addr  input  64  packed {req1, req0} 32-bit addresses.
REQ-007 req_wdata  input  64  packed {req1, req0} 32-bit write data.
REQ-008 req_strb  input  8  packed {req1, req0} 4-bit write strobes.
REQ-009 req_prot  input  6  packed {req1, req0} 3-bit protection.
REQ-010 req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-011 rsp_valid  output  2  one-cycle completion pulse to the owning requester.
REQ-012 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  error flag, valid with rsp_valid.
REQ-014 psel, penable, pwrite  output  1 each  APB master control.
REQ-015 paddr, pwdata  output  32 each  APB address and write data.
REQ-016 pstrb  output  4; pprot  output  3  APB strobes and protection.
REQ-017 prdata  input  32; pready  input  1; pslverr  input  1  APB slave response.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS; IDLE after reset.
REQ-019 IDLE, any req_valid high: grant one requester, drive req_ready[grant]=1 combinationally for that cycle, latch its addr/wdata/strb/prot/write, go to SETUP.
REQ-020 Arbitration: round-robin on 1-bit last_grant; sole requester always wins; both requesting -> winner is ~last_grant; last_grant updates on grant.
REQ-021 SETUP: psel=1, penable=0; go to ACCESS unconditionally next cycle.
REQ-022 ACCESS: psel=1, penable=1; stay while pready=0; on pready=1 go to IDLE.
REQ-023 paddr, pwrite, pwdata, pstrb, pprot come from latched registers and are held constant from SETUP through the final ACCESS cycle.
REQ-024 On reads, pstrb=0 and pwdata=0.
REQ-025 In the cycle after ACCESS with pready=1: rsp_valid[grant]=1, rsp_err=pslverr sampled, rsp_rdata=prdata sampled on reads or 0 on writes; all are registered outputs.
REQ-026 Minimum latency: accept at T, psel at T+1, penable at T+2, rsp_valid at T+3 with zero wait states; minimum 3 cycles per transfer.
REQ-027 Requesters hold req_valid and fields until req_ready; req_valid dropped before grant is ignored with no APB activity.
REQ-028 Outside SETUP/ACCESS: psel=0, penable=0; rsp_valid=0 except the completion cycle.
REQ-029 A new grant can occur in the same cycle as rsp_valid, since the FSM is in IDLE in that cycle.

Reset
REQ-030 presetn=0 at a clock edge: state=IDLE, last_grant=1 (requester 0 wins first), all outputs 0, latched fields 0.
REQ-031 Reset mid-transfer: psel/penable drop at that edge; no rsp_valid is issued for the aborted transfer.

Configuration
REQ-032 APB_ARB_TIMEOUT_EN defined: an ACCESS cycle counter runs, cleared on entry to SETUP; after TIMEOUT_CYCLES consecutive ACCESS cycles with pready=0 the FSM goes to IDLE, psel/penable drop, and next cycle rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0.
REQ-033 APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for pready.

Verification
REQ-034 req0 write addr 0x4000_0010, data 0xA5A5_0001, strb 0xF, pready=1 -> psel T+1, penable T+2, rsp_valid[0] T+3, rsp_err=0.
REQ-035 Both requesters valid after reset -> req0 granted first, req1 next; 4 back-to-back rounds alternate 0,1,0,1.
REQ-036 req1 read, pready low 3 cycles then high with prdata 0xDEAD_BEEF, pslverr=1 -> paddr stable for all 5 phase cycles, rsp_rdata=0xDEAD_BEEF, rsp_err=1, pstrb=0.
REQ-037 presetn low during ACCESS -> psel=0 next edge, no rsp_valid, next grant goes to req0.
REQ-038 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held low -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; without the macro, psel stays high for 100 cycles.
